// File: rtl/segment_transition_if.sv
// ----------------------------------------------------------------------------
// segment_transition_if
//   Bundles the controller-side request, loop and status signals of
//   segment_transition.
//   master : controller / index-counter side (drives requests, time, GPIO,
//            loop_end; observes segment status)
//   slave  : segment_transition itself
//   Signals
//     update           1-cycle pulse, latch a new request
//     req_segment      requested segment (0/1)
//     transition_mode  8'h00 SYNC_IDX, 8'h01 SYS_TIME, 8'h02 GPIO, 8'hF0 EXT
//     transition_value SYS_TIME: [SysTimeW-1:0] target time; GPIO: [1:0] pin
//     rep0, rep1       repeat count per segment (loops = rep+1, all-ones = inf)
//     sys_time         synchronized, monotonic system time
//     gpio_in          asynchronous GPIO inputs
//     loop_end         index counter wrapped to 0
//     segment          active read segment
//     swapped          1-cycle pulse coincident with a segment update
//     stop             finite repetition exhausted
//     waiting          a request is pending its trigger
// ----------------------------------------------------------------------------
interface segment_transition_if #(
    parameter int RepWidth = 16,
    parameter int SysTimeW = 56
);
    logic                update;
    logic                req_segment;
    logic [7:0]          transition_mode;
    logic [63:0]         transition_value;
    logic [RepWidth-1:0] rep0;
    logic [RepWidth-1:0] rep1;
    logic [SysTimeW-1:0] sys_time;
    logic [3:0]          gpio_in;
    logic                loop_end;
    logic                segment;
    logic                swapped;
    logic                stop;
    logic                waiting;

    modport master (
        output update, req_segment, transition_mode, transition_value,
               rep0, rep1, sys_time, gpio_in, loop_end,
        input  segment, swapped, stop, waiting
    );

    modport slave (
        input  update, req_segment, transition_mode, transition_value,
               rep0, rep1, sys_time, gpio_in, loop_end,
        output segment, swapped, stop, waiting
    );
endinterface

// File: rtl/segment_transition.sv
// ----------------------------------------------------------------------------
// segment_transition
//   Chooses which of the two memory segments the sampler reads and when.
//   A request whose segment repeats forever swaps on the next cycle; a finite
//   request waits for its trigger (loop end, system time or a GPIO rising
//   edge). Loop repetitions of a finite segment are counted; when exhausted
//   the block either raises stop or, in EXT mode, ping-pongs to the other
//   segment.
//   Ports
//     i_clk  system clock
//     i_rst  asynchronous, active-high reset
//     bus    segment_transition_if.slave (request, time, GPIO, loop, status)
//   Configuration
//     SEGMENT_TRANSITION_GPIO_EN : include GPIO trigger mode and its input
//     synchronizers. Undefined, gpio_in is unused and mode 8'h02 behaves as
//     SYNC_IDX.
// ----------------------------------------------------------------------------
module segment_transition #(
    parameter int RepWidth = 16,
    parameter int SysTimeW = 56
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    segment_transition_if.slave   bus
);

    localparam logic [7:0] MODE_SYNC_IDX = 8'h00;
    localparam logic [7:0] MODE_SYS_TIME = 8'h01;
    localparam logic [7:0] MODE_GPIO     = 8'h02;
    localparam logic [7:0] MODE_EXT      = 8'hF0;

    localparam logic [RepWidth-1:0] REP_INF = '1;

    typedef enum logic {ST_RUN, ST_WAIT} state_e;

    state_e              r_state,    w_state_nxt;
    logic                r_segment,  w_segment_nxt;
    logic                r_swapped,  w_swapped_nxt;
    logic                r_stop,     w_stop_nxt;
    logic [RepWidth-1:0] r_loop_cnt, w_loop_cnt_nxt;
    // Repeat count and EXT flag of the segment currently being read.
    logic [RepWidth-1:0] r_act_rep,  w_act_rep_nxt;
    logic                r_act_ext,  w_act_ext_nxt;
    // Pending request, valid while in ST_WAIT.
    logic                r_req_seg,  w_req_seg_nxt;
    logic [7:0]          r_req_mode, w_req_mode_nxt;
    logic [RepWidth-1:0] r_req_rep,  w_req_rep_nxt;
    logic [SysTimeW-1:0] r_req_val,  w_req_val_nxt;

    logic [RepWidth-1:0] w_in_rep;
    logic                w_mode_known;
    logic                w_trigger;
    logic                w_unused;

`ifdef SEGMENT_TRANSITION_GPIO_EN
    // Two flops of metastability settling, then a registered rising-edge
    // detect, so a pin change reaches the trigger three cycles later.
    logic [3:0] r_gpio_meta, r_gpio_sync, r_gpio_prev, r_gpio_rise;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_gpio_meta <= '0;
            r_gpio_sync <= '0;
            r_gpio_prev <= '0;
            r_gpio_rise <= '0;
        end else begin
            r_gpio_meta <= bus.gpio_in;
            r_gpio_sync <= r_gpio_meta;
            r_gpio_prev <= r_gpio_sync;
            r_gpio_rise <= r_gpio_sync & ~r_gpio_prev;
        end
    end

    assign w_unused = ^bus.transition_value[63:SysTimeW];
`else
    assign w_unused = ^{bus.gpio_in, bus.transition_value[63:SysTimeW]};
`endif

    assign w_in_rep     = bus.req_segment ? bus.rep1 : bus.rep0;
    assign w_mode_known = (bus.transition_mode == MODE_SYNC_IDX) ||
                          (bus.transition_mode == MODE_SYS_TIME) ||
                          (bus.transition_mode == MODE_GPIO)     ||
                          (bus.transition_mode == MODE_EXT);

    always_comb begin
        w_trigger = bus.loop_end;
        case (r_req_mode)
            MODE_SYS_TIME: w_trigger = (bus.sys_time >= r_req_val);
`ifdef SEGMENT_TRANSITION_GPIO_EN
            MODE_GPIO:     w_trigger = r_gpio_rise[r_req_val[1:0]];
`endif
            default:       w_trigger = bus.loop_end;
        endcase
    end

    // NOTE: every next-state value gets a default before any branch so this
    // block can never infer a latch; unassigned paths simply hold state.
    always_comb begin
        w_state_nxt    = r_state;
        w_segment_nxt  = r_segment;
        w_swapped_nxt  = 1'b0;
        w_stop_nxt     = r_stop;
        w_loop_cnt_nxt = r_loop_cnt;
        w_act_rep_nxt  = r_act_rep;
        w_act_ext_nxt  = r_act_ext;
        w_req_seg_nxt  = r_req_seg;
        w_req_mode_nxt = r_req_mode;
        w_req_rep_nxt  = r_req_rep;
        w_req_val_nxt  = r_req_val;

        if (bus.update) begin
            // A same-cycle loop_end is deliberately dropped here.
            if (w_in_rep == REP_INF) begin
                w_state_nxt    = ST_RUN;
                w_segment_nxt  = bus.req_segment;
                w_swapped_nxt  = 1'b1;
                w_stop_nxt     = 1'b0;
                w_loop_cnt_nxt = '0;
                w_act_rep_nxt  = REP_INF;
                w_act_ext_nxt  = 1'b0;
            end else if (w_mode_known) begin
                w_state_nxt    = ST_WAIT;
                w_req_seg_nxt  = bus.req_segment;
                w_req_mode_nxt = bus.transition_mode;
                w_req_rep_nxt  = w_in_rep;
                w_req_val_nxt  = bus.transition_value[SysTimeW-1:0];
            end
        end else if ((r_state == ST_WAIT) && w_trigger) begin
            // Pending request takes priority over an EXT auto-swap.
            w_state_nxt    = ST_RUN;
            w_segment_nxt  = r_req_seg;
            w_swapped_nxt  = 1'b1;
            w_stop_nxt     = 1'b0;
            w_loop_cnt_nxt = '0;
            w_act_rep_nxt  = r_req_rep;
            w_act_ext_nxt  = (r_req_mode == MODE_EXT);
        end else if (bus.loop_end && (r_act_rep != REP_INF)) begin
            if (r_loop_cnt == r_act_rep) begin
                if (r_act_ext) begin
                    w_segment_nxt  = ~r_segment;
                    w_swapped_nxt  = 1'b1;
                    w_stop_nxt     = 1'b0;
                    w_loop_cnt_nxt = '0;
                    w_act_rep_nxt  = r_segment ? bus.rep0 : bus.rep1;
                end else begin
                    w_stop_nxt = 1'b1;
                end
            end else begin
                // Cannot wrap: the compare above caps it at r_act_rep < all-ones.
                w_loop_cnt_nxt = r_loop_cnt + RepWidth'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_RUN;
            r_segment  <= 1'b0;
            r_swapped  <= 1'b0;
            r_stop     <= 1'b0;
            r_loop_cnt <= '0;
            r_act_rep  <= REP_INF;   // segment 0 starts as infinite
            r_act_ext  <= 1'b0;
            r_req_seg  <= 1'b0;
            r_req_mode <= MODE_SYNC_IDX;
            r_req_rep  <= '0;
            r_req_val  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_segment  <= w_segment_nxt;
            r_swapped  <= w_swapped_nxt;
            r_stop     <= w_stop_nxt;
            r_loop_cnt <= w_loop_cnt_nxt;
            r_act_rep  <= w_act_rep_nxt;
            r_act_ext  <= w_act_ext_nxt;
            r_req_seg  <= w_req_seg_nxt;
            r_req_mode <= w_req_mode_nxt;
            r_req_rep  <= w_req_rep_nxt;
            r_req_val  <= w_req_val_nxt;
        end
    end

    assign bus.segment = r_segment;
    assign bus.swapped = r_swapped;
    assign bus.stop    = r_stop;
    assign bus.waiting = (r_state == ST_WAIT);

endmodule

// File: tb/tb_segment_transition.sv
// ----------------------------------------------------------------------------
// tb_segment_transition
//   Directed bench for segment_transition. Inputs change 1 ns after a rising
//   edge and outputs are compared at that same point, i.e. the value produced
//   by the edge just passed. Observed vector = {segment, swapped, stop, waiting}.
// ----------------------------------------------------------------------------
module tb_segment_transition;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    segment_transition_if #(.RepWidth(16), .SysTimeW(56)) bus ();

    segment_transition #(.RepWidth(16), .SysTimeW(56)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got time %0t required < 200000", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [3:0] obs();
        return {bus.segment, bus.swapped, bus.stop, bus.waiting};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.update           = 1'b0;
        bus.req_segment      = 1'b0;
        bus.transition_mode  = 8'h00;
        bus.transition_value = 64'd0;
        bus.rep0             = 16'hFFFF;
        bus.rep1             = 16'hFFFF;
        bus.sys_time         = 56'd0;
        bus.gpio_in          = 4'b0000;
        bus.loop_end         = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic request(input logic seg, input logic [7:0] mode, input logic [63:0] value);
        bus.update           = 1'b1;
        bus.req_segment      = seg;
        bus.transition_mode  = mode;
        bus.transition_value = value;
        tick();
        bus.update           = 1'b0;
    endtask

    task automatic loop_end_pulse();
        bus.loop_end = 1'b1;
        tick();
        bus.loop_end = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        drive_idle();
        rst = 1'b1;
        tick();
        got = obs();
        if (got !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_values: got %b required %b", got, 4'b0000);
        end
        n_checks++;
        rst = 1'b0;
        tick();
        // Segment 0 is infinite after reset even though rep0 says one loop.
        bus.rep0 = 16'd0;
        for (int i = 0; i < 3; i++) begin
            loop_end_pulse();
            got = obs();
            if (got !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_seg0_infinite[%0d]: got %b required %b", i, got, 4'b0000);
            end
            n_checks++;
        end
    endtask

    task automatic test_immediate();
        logic [3:0] got;
        logic [3:0] exp_seq [3] = '{4'b1100, 4'b1000, 4'b1000};
        do_reset();
        request(1'b1, 8'h01, 64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            got = obs();
            if (got !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL immediate[%0d]: got %b required %b", i, got, exp_seq[i]);
            end
            n_checks++;
            tick();
        end
        // Unknown mode is irrelevant when the requested segment is infinite.
        request(1'b0, 8'h55, 64'd0);
        got = obs();
        if (got !== 4'b0100) begin
            n_fail++;
            $display("FAIL immediate_unknown_mode: got %b required %b", got, 4'b0100);
        end
        n_checks++;
    endtask

    task automatic test_sync_idx();
        logic [3:0] got;
        logic [3:0] exp_seq [4] = '{4'b1100, 4'b1000, 4'b1000, 4'b1010};
        do_reset();
        bus.rep1 = 16'd2;
        request(1'b1, 8'h00, 64'd0);
        for (int i = 0; i < 2; i++) begin
            got = obs();
            if (got !== 4'b0001) begin
                n_fail++;
                $display("FAIL sync_wait[%0d]: got %b required %b", i, got, 4'b0001);
            end
            n_checks++;
            if (i == 0) tick();
        end
        for (int i = 0; i < 4; i++) begin
            loop_end_pulse();
            got = obs();
            if (got !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL sync_loop[%0d]: got %b required %b", i, got, exp_seq[i]);
            end
            n_checks++;
        end
        tick();
        got = obs();
        if (got !== 4'b1010) begin
            n_fail++;
            $display("FAIL sync_stop_held: got %b required %b", got, 4'b1010);
        end
        n_checks++;
        request(1'b0, 8'h00, 64'd0);
        got = obs();
        if (got !== 4'b0100) begin
            n_fail++;
            $display("FAIL sync_stop_cleared: got %b required %b", got, 4'b0100);
        end
        n_checks++;
    endtask

    task automatic test_sys_time();
        logic [3:0] got;
        do_reset();
        bus.rep1     = 16'd5;
        bus.sys_time = 56'd990;
        request(1'b1, 8'h01, 64'd1000);
        for (int st = 991; st <= 1000; st++) begin
            bus.sys_time = 56'(st);
            got = obs();
            if (got !== 4'b0001) begin
                n_fail++;
                $display("FAIL systime_wait[t=%0d]: got %b required %b", st, got, 4'b0001);
            end
            n_checks++;
            tick();
        end
        bus.sys_time = 56'd1001;
        got = obs();
        if (got !== 4'b1100) begin
            n_fail++;
            $display("FAIL systime_swap: got %b required %b", got, 4'b1100);
        end
        n_checks++;
        // Target already in the past: swap lands two cycles after UPDATE.
        bus.rep0 = 16'd3;
        request(1'b0, 8'h01, 64'd500);
        got = obs();
        if (got !== 4'b1001) begin
            n_fail++;
            $display("FAIL systime_past_wait: got %b required %b", got, 4'b1001);
        end
        n_checks++;
        tick();
        got = obs();
        if (got !== 4'b0100) begin
            n_fail++;
            $display("FAIL systime_past_swap: got %b required %b", got, 4'b0100);
        end
        n_checks++;
    endtask

    task automatic test_ext();
        logic [3:0] got;
        logic [3:0] exp_seq [7] = '{4'b1100, 4'b1000, 4'b0100, 4'b1100,
                                   4'b1000, 4'b0100, 4'b1100};
        do_reset();
        bus.rep1 = 16'd1;
        bus.rep0 = 16'd0;
        request(1'b1, 8'hF0, 64'd0);
        got = obs();
        if (got !== 4'b0001) begin
            n_fail++;
            $display("FAIL ext_wait: got %b required %b", got, 4'b0001);
        end
        n_checks++;
        for (int i = 0; i < 7; i++) begin
            loop_end_pulse();
            got = obs();
            if (got !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL ext_loop[%0d]: got %b required %b", i, got, exp_seq[i]);
            end
            n_checks++;
        end
    endtask

    task automatic test_gpio();
        logic [3:0] got;
        do_reset();
        bus.rep1 = 16'd4;
        request(1'b1, 8'h02, 64'd2);
        bus.gpio_in = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            tick();
            got = obs();
            if (got !== 4'b0001) begin
                n_fail++;
                $display("FAIL gpio_other_pin[%0d]: got %b required %b", i, got, 4'b0001);
            end
            n_checks++;
        end
`ifdef SEGMENT_TRANSITION_GPIO_EN
        loop_end_pulse();
        got = obs();
        if (got !== 4'b0001) begin
            n_fail++;
            $display("FAIL gpio_loop_end_ignored: got %b required %b", got, 4'b0001);
        end
        n_checks++;
        bus.gpio_in = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            got = obs();
            if (got !== 4'b0001) begin
                n_fail++;
                $display("FAIL gpio_latency[%0d]: got %b required %b", i, got, 4'b0001);
            end
            n_checks++;
            tick();
        end
        got = obs();
        if (got !== 4'b1100) begin
            n_fail++;
            $display("FAIL gpio_swap: got %b required %b", got, 4'b1100);
        end
        n_checks++;
`else
        bus.gpio_in = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            tick();
            got = obs();
            if (got !== 4'b0001) begin
                n_fail++;
                $display("FAIL gpio_off_pin_ignored[%0d]: got %b required %b", i, got, 4'b0001);
            end
            n_checks++;
        end
        loop_end_pulse();
        got = obs();
        if (got !== 4'b1100) begin
            n_fail++;
            $display("FAIL gpio_off_as_sync_idx: got %b required %b", got, 4'b1100);
        end
        n_checks++;
`endif
    endtask

    task automatic test_corner();
        logic [3:0] got;
        do_reset();
        // UPDATE and LOOP_END together: the loop end must not trigger.
        bus.rep1     = 16'd0;
        bus.loop_end = 1'b1;
        request(1'b1, 8'h00, 64'd0);
        bus.loop_end = 1'b0;
        got = obs();
        if (got !== 4'b0001) begin
            n_fail++;
            $display("FAIL upd_le_no_trigger: got %b required %b", got, 4'b0001);
        end
        n_checks++;
        loop_end_pulse();
        got = obs();
        if (got !== 4'b1100) begin
            n_fail++;
            $display("FAIL upd_le_then_swap: got %b required %b", got, 4'b1100);
        end
        n_checks++;
        // Same again on a one-loop segment: a counted loop end would raise stop.
        bus.loop_end = 1'b1;
        request(1'b1, 8'h00, 64'd0);
        bus.loop_end = 1'b0;
        got = obs();
        if (got !== 4'b1001) begin
            n_fail++;
            $display("FAIL upd_le_no_count: got %b required %b", got, 4'b1001);
        end
        n_checks++;
        // A second request replaces the pending one (sys_time 0 >= 0 fires).
        bus.rep0 = 16'd2;
        request(1'b0, 8'h01, 64'd0);
        got = obs();
        if (got !== 4'b1001) begin
            n_fail++;
            $display("FAIL replace_wait: got %b required %b", got, 4'b1001);
        end
        n_checks++;
        tick();
        got = obs();
        if (got !== 4'b0100) begin
            n_fail++;
            $display("FAIL replace_swap: got %b required %b", got, 4'b0100);
        end
        n_checks++;
        // Unknown mode with a finite count is discarded.
        request(1'b1, 8'h55, 64'd0);
        got = obs();
        if (got !== 4'b0000) begin
            n_fail++;
            $display("FAIL unknown_mode: got %b required %b", got, 4'b0000);
        end
        n_checks++;
        // Reset while waiting drops the request.
        request(1'b1, 8'h00, 64'd0);
        got = obs();
        if (got !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_pre_wait: got %b required %b", got, 4'b0001);
        end
        n_checks++;
        #2;
        rst = 1'b1;
        #1;
        got = obs();
        if (got !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_async: got %b required %b", got, 4'b0000);
        end
        n_checks++;
        tick();
        rst = 1'b0;
        loop_end_pulse();
        got = obs();
        if (got !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_no_swap: got %b required %b", got, 4'b0000);
        end
        n_checks++;
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_sync_idx();
        test_sys_time();
        test_ext();
        test_gpio();
        test_corner();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
